// File: rtl/mul_sched.sv
// Round-robin scheduler in front of one shared iterative shift-add multiplier.
// One transaction in flight; result held until the consumer accepts it.
module mul_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [1:0]            res_id,
  output logic                  busy
);

  localparam int unsigned IDW = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m1, m2, acc;
  logic [IDW-1:0]   id, last;

  logic             any;
  logic [IDW-1:0]   win, cand;
  int unsigned      idx;
  logic [WIDTH-1:0] a_sel, b_sel, acc_nxt, m2_nxt;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    idx  = 0;
    cand = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(last) + k) % NREQ;
      cand = idx[IDW-1:0];
      if (!any && req_valid[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any && !RST)
      req_ready[win] = 1'b1;
  end

  assign a_sel   = req_a[32'(win)*WIDTH +: WIDTH];
  assign b_sel   = req_b[32'(win)*WIDTH +: WIDTH];
  assign acc_nxt = m2[0] ? acc + m1 : acc;
  assign m2_nxt  = m2 >> 1;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      m1        <= '0;
      m2        <= '0;
      acc       <= '0;
      id        <= '0;
      last      <= IDW'(NREQ - 1);
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            m1    <= a_sel;
            m2    <= b_sel;
            acc   <= '0;
            id    <= win;
            last  <= win;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          m1  <= m1 << 1;
          m2  <= m2_nxt;
          // Early exit once no multiplier bits remain; b=0 still takes one cycle.
          if (m2_nxt == '0) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_data  <= acc_nxt;
            res_id    <= id;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched: latency, products, fairness,
// backpressure and asynchronous reset during a transaction.
module tb_mul_sched;

  logic        CK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  mul_sched #(.WIDTH(16), .NREQ(4)) dut (
    .CK(CK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  // Drives one transaction from requester r; lat = -1 if it never completes.
  task automatic run_one(input int r, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] d,
                         output logic [1:0] id, output logic rv_after);
    bit got;
    lat = -1; d = '0; id = '0; rv_after = 1'b1; got = 0;
    res_ready = 1'b1;
    req_a[r*16 +: 16] = a;
    req_b[r*16 +: 16] = b;
    req_valid = '0;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CK);
      if (req_ready[r]) got = 1;
    end
    if (got) begin
      @(posedge CK); #1 req_valid = '0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge CK); #1;
        if (res_valid) begin
          lat = i; d = res_data; id = res_id;
          break;
        end
      end
      if (lat > 0) begin
        @(posedge CK); #1 rv_after = res_valid;
      end
    end else begin
      req_valid = '0;
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    #12;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data got %h want 0000", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got %0d want 0", res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    @(negedge CK); RST = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    int lat; logic [15:0] d; logic [1:0] id; logic rva;
    run_one(0, 16'd3, 16'd5, lat, d, id, rva);
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat); end
    checks++; if (d !== 16'd15) begin errors++; $display("FAIL single_data got %h want 000f", d); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", id); end
    checks++; if (rva !== 1'b0) begin errors++; $display("FAIL single_valid_one_cycle got %b want 0", rva); end
  endtask

  task automatic test_zero_one();
    int lat; logic [15:0] d; logic [1:0] id; logic rva;
    run_one(0, 16'h1234, 16'h0000, lat, d, id, rva);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL zero_data got %h want 0000", d); end
    run_one(3, 16'h1234, 16'h0001, lat, d, id, rva);
    checks++; if (lat !== 1) begin errors++; $display("FAIL one_latency got %0d want 1", lat); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL one_data got %h want 1234", d); end
    checks++; if (id !== 2'd3) begin errors++; $display("FAIL one_id got %0d want 3", id); end
  endtask

  task automatic test_overflow();
    int lat; logic [15:0] d; logic [1:0] id; logic rva;
    run_one(1, 16'hFFFF, 16'hFFFF, lat, d, id, rva);
    checks++; if (lat !== 16) begin errors++; $display("FAIL ovf_latency got %0d want 16", lat); end
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ovf_data got %h want 0001", d); end
    run_one(2, 16'h0100, 16'h0100, lat, d, id, rva);
    checks++; if (lat !== 9) begin errors++; $display("FAIL trunc_latency got %0d want 9", lat); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL trunc_data got %h want 0000", d); end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [15:0] exp_d  [6] = '{16'd6, 16'd12, 16'd20, 16'd30, 16'd6, 16'd12};
    logic [1:0]  got_id [6];
    logic [15:0] got_d  [6];
    int n = 0;
    #2 RST = 1'b1; #2 RST = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(i + 2);
      req_b[i*16 +: 16] = 16'(i + 3);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 300 && n < 6; c++) begin
      @(posedge CK); #1;
      if (res_valid) begin
        got_id[n] = res_id; got_d[n] = res_data; n++;
      end
    end
    req_valid = '0;
    checks++; if (n !== 6) begin errors++; $display("FAIL fair_count got %0d want 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got_id[i] !== exp_id[i]) begin errors++; $display("FAIL fair_id[%0d] got %0d want %0d", i, got_id[i], exp_id[i]); end
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL fair_data[%0d] got %0d want %0d", i, got_d[i], exp_d[i]); end
    end
    @(posedge CK); #1;
  endtask

  task automatic test_backpressure();
    bit got = 0, done = 0;
    #2 RST = 1'b1; #2 RST = 1'b0;
    res_ready = 1'b0;
    req_a[15:0] = 16'd7; req_b[15:0] = 16'd9;
    req_valid = 4'b0001;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CK);
      if (req_ready[0]) got = 1;
    end
    @(posedge CK); #1 req_valid = 4'b0010;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge CK); #1;
      if (res_valid) done = 1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_result_timeout got %b want 1", done); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CK);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, res_valid); end
      checks++; if (res_data !== 16'd63) begin errors++; $display("FAIL bp_data[%0d] got %0d want 63", k, res_data); end
      checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL bp_id[%0d] got %0d want 0", k, res_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready[%0d] got %b want 0000", k, req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d] got %b want 1", k, busy); end
    end
    res_ready = 1'b1;
    req_valid = '0;
    @(posedge CK); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    bit got = 0, done = 0;
    res_ready = 1'b1;
    req_a[47:32] = 16'd5;  req_b[47:32] = 16'h8000;
    req_a[31:16] = 16'h11; req_b[31:16] = 16'd3;
    req_valid = 4'b0100;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CK);
      if (req_ready[2]) got = 1;
    end
    @(posedge CK); #1 req_valid = 4'b0110;
    repeat (3) @(posedge CK);
    #2 RST = 1'b1; #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL rst_res_data got %h want 0000", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rst_res_id got %0d want 0", res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    repeat (3) begin
      @(posedge CK); #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got %b want 0", res_valid); end
    end
    @(negedge CK); RST = 1'b0; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_next_grant got %b want 0010", req_ready); end
    @(posedge CK); #1 req_valid = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge CK); #1;
      if (res_valid) done = 1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_after_timeout got %b want 1", done); end
    checks++; if (res_id !== 2'd1) begin errors++; $display("FAIL rst_after_id got %0d want 1", res_id); end
    checks++; if (res_data !== 16'h0033) begin errors++; $display("FAIL rst_after_data got %h want 0033", res_data); end
    @(posedge CK); #1;
  endtask

  initial begin
    RST = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    test_reset();
    test_single();
    test_zero_one();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler and sequencer for a shared iterative shift-add multiplier. The block accepts operand pairs from up to `NREQ` requesters using valid/ready handshakes and grants one requester at a time. It runs the multiply with early termination and returns the truncated product tagged with the requester index. It sits between the ALU front-ends and the single multiply resource, replacing per-requester multipliers.

## Interface
- `WIDTH`, 16, operand/result width in bits
- `NREQ`, 4, number of requesters (2..4); `IDW` = 2 fixed
- `CK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero
- `req_a`  in  NREQ*WIDTH  multiplicands; requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  multipliers, same packing
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumer accept
- `res_data`  out  WIDTH  product, low WIDTH bits of a*b
- `res_id`  out  2  index of requester that owns `res_data`
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `last+1` upward with wrap modulo NREQ.
  - `req_ready[winner]` = 1 combinationally. All other bits are 0. All bits are 0 if no valid.
  - On handshake (valid & ready at a rising edge):
    - capture m1 = a, m2 = b, acc = 0, id = winner;
    - set `last` = winner;
    - go to RUN.
- RUN, each cycle:
  - if m2[0], acc = acc + m1 (mod 2^WIDTH);
  - m1 = m1 << 1; m2 = m2 >> 1;
  - if the new m2 == 0, go to DONE and load `res_data` = acc (including this cycle's add) and `res_id` = id.
- DONE:
  - `res_valid` = 1.
  - `res_data` and `res_id` are held stable until `res_ready`.
  - On `res_valid & res_ready`, go to IDLE and drop `res_valid`.
- `req_ready` is 0 in RUN and DONE. No new operands are accepted until the result is consumed.
- Requesters hold `req_valid`/operands until accepted. The arbiter re-evaluates every IDLE cycle. A requester that drops valid before grant simply loses arbitration.
- Arithmetic: truncated unsigned product. Overflow bits are discarded and no flag is raised.

## Timing
- Reset values:
  - state IDLE;
  - `res_valid` 0, `res_data` 0, `res_id` 0, `busy` 0;
  - `req_ready` 0 (forced 0 while RST high);
  - `last` = NREQ-1, so requester 0 wins first.
- Let E0 be the handshake edge. RUN lasts n = max(1, msb(b)+1) cycles: n = 1 for b = 0 or 1, n = 16 for b[15] = 1.
- `res_valid` rises after edge E0+n.
- Earliest return to IDLE is edge E0+n+1, when `res_ready` is high in the first DONE cycle. The next handshake is at edge E0+n+2 at the earliest.
- `busy` rises after E0 and falls after the DONE→IDLE edge.
- Simultaneous valids: exactly one grant per IDLE cycle, in round-robin order. Under continuous load, no requester waits more than NREQ-1 other transactions.
- `res_ready` high outside DONE has no effect.
- RST asserted mid-RUN or mid-DONE:
  - immediate return to reset values; the in-flight transaction is lost with no result;
  - the pointer resets to NREQ-1.
- A `req_valid` change during RUN/DONE is ignored. A `req_a`/`req_b` change after handshake does not affect the in-flight product.

## Test plan
- Single transaction: req0 a=3, b=5, `res_ready`=1 → 3 RUN cycles, `res_data`=15, `res_id`=0, `res_valid` high exactly 1 cycle.
- Zero and one multipliers:
  - a=0x1234, b=0 → 1 RUN cycle, result 0x0000.
  - a=0x1234, b=1 → 1 RUN cycle, result 0x1234.
- Overflow/long run:
  - a=0xFFFF, b=0xFFFF → 16 RUN cycles, result 0x0001.
  - a=0x0100, b=0x0100 → result 0x0000.
- Fairness: all 4 `req_valid` held high, distinct operands → grant/`res_id` order 0,1,2,3,0,1. Each product is correct for its requester.
- Backpressure: `res_ready` low for 5 DONE cycles → `res_valid`, `res_data` and `res_id` stable, all `req_ready`=0, `busy`=1. Then `res_ready`=1 → IDLE next edge.
- Reset mid-op: RST pulsed during RUN of req2 → all outputs return to reset values asynchronously, no result emitted. With req1 and req2 both valid afterwards, the next grant is req1.
